// File: rtl/mux_sel_scan.sv
// Select sequencer feeding an 8:1 mux as a parallel-to-serial path.
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_data
// (word handshake), flush (sync abort), a/s (mux data and select),
// bit_valid/bit_last (per-bit markers), busy (word in progress).
module mux_sel_scan #(
  parameter int unsigned HOLD      = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:8] in_data,
  input  logic       flush,
  output logic [1:8] a,
  output logic [1:3] s,
  output logic       bit_valid,
  output logic       bit_last,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [1:3] S_START =
    MSB_FIRST ? 3'b000 : 3'b111;
  localparam logic [1:3] S_END =
    MSB_FIRST ? 3'b111 : 3'b000;
  localparam logic [3:0] H_LAST = 4'(HOLD - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic       step_done;
  logic       fin;
  logic       accept;
  logic [1:3] s_step;

  assign step_done = (hold_cnt == H_LAST);

  // Last cycle of the last select position of the word.
  assign fin = (state == SCAN)
            && (s == S_END)
            && step_done;

  // A new word may enter while idle or on the final bit
  // of the current one, which gives gap-free streaming.
  assign in_ready = !rst && !flush
                 && ((state == IDLE) || fin);

  assign accept = in_valid && in_ready;

  assign s_step = MSB_FIRST ? (s + 3'd1) : (s - 3'd1);

  assign bit_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign bit_last  = fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      s        <= S_START;
      hold_cnt <= '0;
    end else if (flush) begin
      state    <= IDLE;
      a        <= '0;
      s        <= S_START;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a        <= in_data;
            s        <= S_START;
            hold_cnt <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!step_done) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else if (s != S_END) begin
            // End of word is s==S_END, so s never wraps here.
            hold_cnt <= '0;
            s        <= s_step;
          end else if (accept) begin
            a        <= in_data;
            s        <= S_START;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= '0;
            s        <= S_START;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_scan.sv
// Bench for mux_sel_scan: two instances (ascending HOLD=1,
// descending HOLD=3) checked every cycle against a word/index model.
module tb_mux_sel_scan;

  localparam int H0 = 1;
  localparam int H1 = 3;
  localparam bit M0 = 1'b1;
  localparam bit M1 = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       v    [2];
  logic [1:8] din  [2];
  logic       fl   [2];
  logic       rdy  [2];
  logic [1:8] a_o  [2];
  logic [1:3] s_o  [2];
  logic       bv   [2];
  logic       bl   [2];
  logic       bz   [2];

  int tests = 0;
  int fails = 0;
  int tmo = 0;
  int tmo_seen = 0;

  // model: word in flight and flat cycle index inside it
  bit         act [2];
  int         k   [2];
  logic [1:8] w   [2];

  // serial stream capture and literal pins
  logic [23:0] slog    [2];
  int          sn      [2];
  int          wdone   [2];
  int          pin_id  [2];
  logic [23:0] pin_val [2];
  int          pin_n   [2];

  always #5 clk = ~clk;

  mux_sel_scan #(.HOLD(H0), .MSB_FIRST(M0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(v[0]), .in_ready(rdy[0]),
    .in_data(din[0]), .flush(fl[0]),
    .a(a_o[0]), .s(s_o[0]),
    .bit_valid(bv[0]), .bit_last(bl[0]),
    .busy(bz[0])
  );

  mux_sel_scan #(.HOLD(H1), .MSB_FIRST(M1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(v[1]), .in_ready(rdy[1]),
    .in_data(din[1]), .flush(fl[1]),
    .a(a_o[1]), .s(s_o[1]),
    .bit_valid(bv[1]), .bit_last(bl[1]),
    .busy(bz[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 0) ? M0 : M1;
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t",
               nm, d, got, exp, $time);
    end
  endtask

  // model update: a word is 8*HOLD consecutive cycles
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      int         nk;
      bit         na;
      bit         rd;
      logic [1:8] nw;
      nk = k[d];
      na = act[d];
      nw = w[d];
      if (rst || fl[d]) begin
        na = 1'b0;
        nk = 0;
        nw = '0;
      end else begin
        rd = !na || (nk == 8 * hold_of(d) - 1);
        if (na) begin
          nk = nk + 1;
          if (nk == 8 * hold_of(d)) na = 1'b0;
        end
        if (v[d] && rd) begin
          na = 1'b1;
          nk = 0;
          nw = din[d];
        end
      end
      act[d] <= na;
      k[d]   <= nk;
      w[d]   <= nw;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int hl;
      int p;
      int es;
      int si;
      bit ey;
      bit er;
      bit lc;
      bit dy;
      hl = hold_of(d);
      si = int'(s_o[d]);
      dy = a_o[d][si + 1];
      er = !rst && !fl[d]
        && (!act[d] || (k[d] == 8 * hl - 1));
      check("in_ready", d, 32'(rdy[d]), 32'(er));
      if (rst || !act[d]) begin
        es = msb_of(d) ? 0 : 7;
        check("idle_valid", d, 32'(bv[d]), 32'd0);
        check("idle_busy", d, 32'(bz[d]), 32'd0);
        check("idle_last", d, 32'(bl[d]), 32'd0);
        check("idle_s", d, 32'(s_o[d]), 32'(es));
        check("idle_a", d, 32'(a_o[d]),
              rst ? 32'd0 : 32'(w[d]));
      end else begin
        p  = k[d] / hl;
        es = msb_of(d) ? p : 7 - p;
        ey = msb_of(d) ? w[d][p + 1] : w[d][8 - p];
        lc = (k[d] == 8 * hl - 1);
        check("scan_valid", d, 32'(bv[d]), 32'd1);
        check("scan_busy", d, 32'(bz[d]), 32'd1);
        check("scan_last", d, 32'(bl[d]), 32'(lc));
        check("scan_s", d, 32'(s_o[d]), 32'(es));
        check("scan_a", d, 32'(a_o[d]), 32'(w[d]));
        check("scan_y", d, 32'(dy), 32'(ey));
      end
      if (bv[d]) begin
        slog[d] = {slog[d][22:0], dy};
        sn[d]   = sn[d] + 1;
        if (bl[d]) begin
          wdone[d] = wdone[d] + 1;
          if (pin_id[d] == wdone[d]) begin
            check("pin_stream", d, 32'(slog[d]),
                  32'(pin_val[d]));
            check("pin_len", d, 32'(sn[d]),
                  32'(pin_n[d]));
          end
          slog[d] = '0;
          sn[d]   = 0;
        end
      end else begin
        slog[d] = '0;
        sn[d]   = 0;
      end
    end
    if (tmo != tmo_seen) begin
      check("handshake_timeout", 0, 32'(tmo),
            32'(tmo_seen));
      tmo_seen = tmo;
    end
  end

  task automatic pin(input int d,
                     input logic [23:0] val,
                     input int n);
    pin_id[d]  = wdone[d] + 1;
    pin_val[d] = val;
    pin_n[d]   = n;
  endtask

  task automatic send(input int d,
                      input logic [1:8] wd,
                      input bit keep);
    bit got;
    got   = 1'b0;
    v[d]   = 1'b1;
    din[d] = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo++;
    @(posedge clk);
    #1;
    if (!keep) v[d] = 1'b0;
  endtask

  // keep in_valid high with churning data until accepted
  task automatic wait_random(input int d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      din[d] = 8'($urandom);
    end
    if (!got) tmo++;
    @(posedge clk);
    #1;
    v[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      v[d]      = 1'b0;
      din[d]    = '0;
      fl[d]     = 1'b0;
      pin_id[d] = 0;
      pin_val[d] = '0;
      pin_n[d]  = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single word on both instances
    pin(0, 24'h00004D, 8);
    pin(1, 24'hE3F038, 24);
    v[0] = 1'b1;
    v[1] = 1'b1;
    din[0] = 8'b01001101;
    din[1] = 8'b01001101;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // back-to-back with in_valid held high
    pin(0, 24'h0000A5, 8);
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b0);
    pin(0, 24'h00003C, 8);
    repeat (12) @(posedge clk);
    #1;

    // flush on the 4th bit, with a competing in_valid
    send(0, 8'hB2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    fl[0]  = 1'b1;
    v[0]   = 1'b1;
    din[0] = 8'hFF;
    @(posedge clk);
    #1;
    fl[0] = 1'b0;
    v[0]  = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // asynchronous reset between edges mid-word
    v[0] = 1'b1;
    v[1] = 1'b1;
    din[0] = 8'h96;
    din[1] = 8'h96;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    pin(0, 24'h00005A, 8);
    pin(1, 24'h1C7E38, 24);
    v[0] = 1'b1;
    v[1] = 1'b1;
    din[0] = 8'h5A;
    din[1] = 8'h5A;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // in_valid held while blocked, data changing
    send(1, 8'hC3, 1'b1);
    wait_random(1);
    repeat (30) @(posedge clk);
    #1;

    // randomized traffic with occasional flush
    repeat (500) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        v[d]   = 1'($urandom_range(0, 1));
        din[d] = 8'($urandom);
        fl[d]  = ($urandom_range(0, 31) == 0);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      v[d]  = 1'b0;
      fl[d] = 1'b0;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
